// File: rtl/demo_frame_sequencer.sv
// demo_frame_sequencer
//   Frame-rate scheduler for the demoscene video path. Turns vsync into a
//   one-cycle frame tick and, on every applied tick, steps three bouncing
//   layer offsets, a scene timer and a four-state scene FSM.
//
// Parameters
//   OFFSET_MAX        upper bounce limit of every offset
//   SCENE_FRAMES      frame ticks spent in each scene (1..4095)
//   VSYNC_ACTIVE_LOW  1: frame starts on vsync falling edge, 0: rising edge
//
// Ports
//   clk, rst_n           pixel clock, asynchronous active-low reset
//   vsync                raw vsync from hvsync_generator (asynchronous)
//   pause                level, freezes all animation state
//   step                 asynchronous pushbutton, one update while paused
//   speed[1:0]           offset increment per frame minus one
//   off0/off1/off2[9:0]  bouncing offsets for the r/g/b layers
//   layer_en[2:0]        per-layer box enables {b,g,r}
//   bitmap_en            bitmap overlay enable
//   scene[1:0]           current scene state
//   pal_rot[1:0]         colour rotation 0..2
//   frame_tick           one-cycle pulse marking an applied frame update
module demo_frame_sequencer #(
  parameter int unsigned OFFSET_MAX       = 200,
  parameter int unsigned SCENE_FRAMES     = 240,
  parameter bit          VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync,
  input  logic       pause,
  input  logic       step,
  input  logic [1:0] speed,
  output logic [9:0] off0,
  output logic [9:0] off1,
  output logic [9:0] off2,
  output logic [2:0] layer_en,
  output logic       bitmap_en,
  output logic [1:0] scene,
  output logic [1:0] pal_rot,
  output logic       frame_tick
);

  localparam logic        VS_IDLE = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [9:0]  OMAX    = 10'(OFFSET_MAX);
  localparam logic [9:0]  OMID    = 10'(OFFSET_MAX / 2);
  localparam logic [11:0] TLAST   = 12'(SCENE_FRAMES - 1);

  typedef enum logic [1:0] {
    S_BOXES  = 2'd0,
    S_BITMAP = 2'd1,
    S_MIX    = 2'd2,
    S_INVERT = 2'd3
  } scene_t;

  // ---------------------------------------------------------------- vsync
  logic vs_s1, vs_s2, vs_s3;
  logic vld1, vld2, armed;
  logic tick_r;
  logic vs_act, vs_prev_act;

  assign vs_act      = vs_s2 ^ VS_IDLE;
  assign vs_prev_act = vs_s3 ^ VS_IDLE;

  // armed stays low until the synchroniser has seen a real deasserted
  // sample, so a vsync already asserted when reset releases gives no tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s1  <= VS_IDLE;
      vs_s2  <= VS_IDLE;
      vs_s3  <= VS_IDLE;
      vld1   <= 1'b0;
      vld2   <= 1'b0;
      armed  <= 1'b0;
      tick_r <= 1'b0;
    end else begin
      vs_s1  <= vsync;
      vs_s2  <= vs_s1;
      vs_s3  <= vs_s2;
      vld1   <= 1'b1;
      vld2   <= vld1;
      armed  <= armed | (vld2 & ~vs_act);
      tick_r <= armed & vs_act & ~vs_prev_act;
    end
  end

  // ----------------------------------------------------------------- step
  logic st_s1, st_s2, st_s3;
  logic step_rise_r;
  logic step_pending;
  logic apply;

  assign apply = tick_r & (~pause | step_pending);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_s1        <= 1'b0;
      st_s2        <= 1'b0;
      st_s3        <= 1'b0;
      step_rise_r  <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      st_s1       <= step;
      st_s2       <= st_s1;
      st_s3       <= st_s2;
      step_rise_r <= st_s2 & ~st_s3;
      // A press landing together with a tick arms the next tick rather
      // than the current one.
      if (!pause)
        step_pending <= 1'b0;
      else if (step_rise_r)
        step_pending <= 1'b1;
      else if (apply)
        step_pending <= 1'b0;
    end
  end

  // -------------------------------------------------------------- offsets
  // Returns {dir, off}; dir 0 = up, 1 = down. The sum is one bit wider so
  // the top check cannot wrap.
  function automatic logic [10:0] bounce(input logic [9:0] off,
                                         input logic       dir,
                                         input logic [2:0] s);
    logic [10:0] sum;
    sum = {1'b0, off} + 11'(s);
    if (!dir) begin
      if (sum >= {1'b0, OMAX}) bounce = {1'b1, OMAX};
      else                     bounce = {1'b0, sum[9:0]};
    end else begin
      if (off <= 10'(s)) bounce = {1'b0, 10'd0};
      else               bounce = {1'b1, off - 10'(s)};
    end
  endfunction

  logic [9:0] off_q [3];
  logic       dir_q [3];
  logic [9:0] off_d [3];
  logic       dir_d [3];
  logic [2:0] inc;

  always_comb begin
    inc = {1'b0, speed} + 3'd1;
    for (int unsigned i = 0; i < 3; i++) begin
      {dir_d[i], off_d[i]} = bounce(off_q[i], dir_q[i], inc);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q[0] <= '0;
      off_q[1] <= 10'd100;
      off_q[2] <= OMID;
      dir_q[0] <= 1'b0;
      dir_q[1] <= 1'b1;
      dir_q[2] <= 1'b0;
    end else if (apply) begin
      for (int unsigned i = 0; i < 3; i++) begin
        off_q[i] <= off_d[i];
        dir_q[i] <= dir_d[i];
      end
    end
  end

  assign off0 = off_q[0];
  assign off1 = off_q[1];
  assign off2 = off_q[2];

  // ------------------------------------------------------ timer and scene
  scene_t      state_q, state_d;
  logic [11:0] timer_q, timer_d;
  logic [1:0]  pal_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    pal_d   = pal_rot;
    if (apply) begin
      if (timer_q == TLAST) begin
        timer_d = '0;
        unique case (state_q)
          S_BOXES:  state_d = S_BITMAP;
          S_BITMAP: state_d = S_MIX;
          S_MIX:    state_d = S_INVERT;
          S_INVERT: begin
            state_d = S_BOXES;
            pal_d   = (pal_rot == 2'd2) ? 2'd0 : pal_rot + 2'd1;
          end
          default:  state_d = S_BOXES;
        endcase
      end else begin
        timer_d = timer_q + 12'd1;
      end
    end
  end

  function automatic logic [3:0] decode(input scene_t s);
    unique case (s)
      S_BOXES:  decode = {3'b111, 1'b0};
      S_BITMAP: decode = {3'b000, 1'b1};
      S_MIX:    decode = {3'b011, 1'b1};
      S_INVERT: decode = {3'b111, 1'b1};
      default:  decode = {3'b111, 1'b0};
    endcase
  endfunction

  // Enables are registered from the next state so they move together
  // with scene.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOXES;
      timer_q    <= '0;
      pal_rot    <= '0;
      layer_en   <= 3'b111;
      bitmap_en  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state_q                <= state_d;
      timer_q                <= timer_d;
      pal_rot                <= pal_d;
      {layer_en, bitmap_en}  <= decode(state_d);
      frame_tick             <= apply;
    end
  end

  assign scene = state_q;

endmodule

// File: tb/tb_demo_frame_sequencer.sv
module tb_demo_frame_sequencer;

  localparam int OMAX = 200;
  localparam int SF_A = 2;

  logic       clk = 1'b0;
  logic       rst_n, vsync_a, vsync_b, pause, step;
  logic [1:0] speed;
  logic [9:0] off0_a, off1_a, off2_a, off0_b, off1_b, off2_b;
  logic [2:0] le_a, le_b;
  logic       be_a, be_b, ft_a, ft_b;
  logic [1:0] sc_a, sc_b, pr_a, pr_b;

  always #5 clk = ~clk;

  demo_frame_sequencer #(.OFFSET_MAX(200), .SCENE_FRAMES(SF_A), .VSYNC_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .vsync(vsync_a), .pause(pause), .step(step), .speed(speed),
    .off0(off0_a), .off1(off1_a), .off2(off2_a), .layer_en(le_a), .bitmap_en(be_a),
    .scene(sc_a), .pal_rot(pr_a), .frame_tick(ft_a));

  demo_frame_sequencer #(.OFFSET_MAX(200), .SCENE_FRAMES(240), .VSYNC_ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .vsync(vsync_b), .pause(pause), .step(step), .speed(speed),
    .off0(off0_b), .off1(off1_b), .off2(off2_b), .layer_en(le_b), .bitmap_en(be_b),
    .scene(sc_b), .pal_rot(pr_b), .frame_tick(ft_b));

  typedef struct {
    int o0, o1, o2, sc, le, be, pr, due;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   b_ticks = 0;
  int   b_cyc = 0;
  bit   seen_top = 0;
  bit   seen_zero = 0;

  int   m_off[3];
  bit   m_dir[3];
  int   m_tim, m_sc, m_pr;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int le_of(input int s);
    case (s)
      0: le_of = 7;
      1: le_of = 0;
      2: le_of = 3;
      default: le_of = 7;
    endcase
  endfunction

  task automatic m_reset();
    m_off[0] = 0;   m_dir[0] = 0;
    m_off[1] = 100; m_dir[1] = 1;
    m_off[2] = OMAX / 2; m_dir[2] = 0;
    m_tim = 0; m_sc = 0; m_pr = 0;
    q.delete();
  endtask

  task automatic m_apply(input int due);
    int s;
    exp_t e;
    s = int'(speed) + 1;
    for (int i = 0; i < 3; i++) begin
      if (!m_dir[i]) begin
        if (m_off[i] + s >= OMAX) begin m_off[i] = OMAX; m_dir[i] = 1; end
        else m_off[i] = m_off[i] + s;
      end else begin
        if (m_off[i] <= s) begin m_off[i] = 0; m_dir[i] = 0; end
        else m_off[i] = m_off[i] - s;
      end
    end
    if (m_tim == SF_A - 1) begin
      m_tim = 0;
      if (m_sc == 3) begin m_sc = 0; m_pr = (m_pr + 1) % 3; end
      else m_sc = m_sc + 1;
    end else begin
      m_tim = m_tim + 1;
    end
    e.o0 = m_off[0]; e.o1 = m_off[1]; e.o2 = m_off[2];
    e.sc = m_sc; e.le = le_of(m_sc); e.be = (m_sc != 0) ? 1 : 0; e.pr = m_pr;
    e.due = due;
    q.push_back(e);
  endtask

  // One active-low pulse on dut_a: 3 clk asserted, 7 clk idle.
  task automatic pulse_a(input bit applies);
    @(negedge clk);
    vsync_a = 1'b0;
    if (applies) m_apply(cyc + 4);
    repeat (3) @(negedge clk);
    vsync_a = 1'b1;
    repeat (7) @(negedge clk);
  endtask

  task automatic press_step();
    @(negedge clk);
    step = 1'b1;
    repeat (4) @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_off0"}, 32'(off0_a), 0);
    chk({tag, "_off1"}, 32'(off1_a), 100);
    chk({tag, "_off2"}, 32'(off2_a), 100);
    chk({tag, "_scene"}, 32'(sc_a), 0);
    chk({tag, "_layer_en"}, 32'(le_a), 7);
    chk({tag, "_bitmap_en"}, 32'(be_a), 0);
    chk({tag, "_pal_rot"}, 32'(pr_a), 0);
    chk({tag, "_frame_tick"}, 32'(ft_a), 0);
  endtask

  // Scoreboard: every frame_tick from dut_a pops one expected update.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ft_a !== 1'b0) begin
      chk("tick_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("latency", cyc, e.due);
        chk("off0", 32'(off0_a), e.o0);
        chk("off1", 32'(off1_a), e.o1);
        chk("off2", 32'(off2_a), e.o2);
        chk("scene", 32'(sc_a), e.sc);
        chk("layer_en", 32'(le_a), e.le);
        chk("bitmap_en", 32'(be_a), e.be);
        chk("pal_rot", 32'(pr_a), e.pr);
      end
      chk("off0_range", 32'(off0_a <= 10'd200), 1);
      chk("off1_range", 32'(off1_a <= 10'd200), 1);
      if (off0_a == 10'd200) seen_top = 1;
      if (off1_a == 10'd0) seen_zero = 1;
    end
    if (rst_n === 1'b1 && ft_b === 1'b1) begin
      b_ticks++;
      b_cyc = cyc;
    end
  end

  initial begin
    int c0;
    logic [9:0] f0;
    logic [1:0] fsc;
    rst_n = 1'b0; vsync_a = 1'b1; vsync_b = 1'b0;
    pause = 1'b0; step = 1'b0; speed = 2'd0;
    m_reset();
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Active-high instance: one tick on the rising edge of a 10-clk pulse.
    c0 = cyc;
    vsync_b = 1'b1;
    repeat (10) @(negedge clk);
    vsync_b = 1'b0;
    repeat (10) @(negedge clk);
    chk("b_tick_count", b_ticks, 1);
    chk("b_tick_latency", b_cyc, c0 + 4);
    chk("b_off0", 32'(off0_b), 1);
    chk("b_off1", 32'(off1_b), 99);

    // Five frames at speed 0.
    for (int i = 0; i < 5; i++) pulse_a(1);
    chk("five_off0", 32'(off0_a), 5);
    chk("five_off1", 32'(off1_a), 95);
    chk("five_off2", 32'(off2_a), 105);

    // Three more: eight ticks with two frames per scene wrap to BOXES.
    for (int i = 0; i < 3; i++) pulse_a(1);
    chk("eight_scene", 32'(sc_a), 0);
    chk("eight_pal_rot", 32'(pr_a), 1);

    // Fast bounce through both limits.
    speed = 2'd3;
    for (int i = 0; i < 110; i++) pulse_a(1);
    chk("seen_top", 32'(seen_top), 1);
    chk("seen_zero", 32'(seen_zero), 1);
    speed = 2'd1;
    pulse_a(1);

    // Paused: frames are ignored.
    @(negedge clk);
    pause = 1'b1;
    f0 = off0_a; fsc = sc_a;
    for (int i = 0; i < 4; i++) pulse_a(0);
    chk("paused_off0", 32'(off0_a), 32'(f0));
    chk("paused_scene", 32'(sc_a), 32'(fsc));

    // One step press allows exactly one update.
    press_step();
    pulse_a(1);
    pulse_a(0);
    pulse_a(0);

    // Step pressed while running does not carry into a later pause.
    pause = 1'b0;
    press_step();
    repeat (4) @(negedge clk);
    pause = 1'b1;
    pulse_a(0);
    pulse_a(0);

    // Step edge coincides with a tick while paused: consumed at the next one.
    @(negedge clk);
    vsync_a = 1'b0;
    step = 1'b1;
    repeat (3) @(negedge clk);
    vsync_a = 1'b1;
    step = 1'b0;
    repeat (7) @(negedge clk);
    pulse_a(1);
    pulse_a(0);

    // Pause released in the cycle the tick is applied.
    @(negedge clk);
    vsync_a = 1'b0;
    m_apply(cyc + 4);
    repeat (3) @(negedge clk);
    pause = 1'b0;
    vsync_a = 1'b1;
    repeat (7) @(negedge clk);
    pulse_a(1);

    // Asynchronous reset mid-run, released with vsync held asserted.
    speed = 2'd2;
    for (int i = 0; i < 7; i++) pulse_a(1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    vsync_a = 1'b0;
    m_reset();
    #1;
    chk_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_tick_after_release_off0", 32'(off0_a), 0);
    vsync_a = 1'b1;
    repeat (5) @(negedge clk);
    pulse_a(1);
    chk("post_reset_off0", 32'(off0_a), 3);

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
